// File: rtl/result_writer_pkg.sv
// Shared types for result_writer: the result-queue read structs and the
// writer package (state enum, default widths, bytes per word).
package structs;

  typedef struct packed {
    logic        empty;
    logic [31:0] q;
  } struct_resultQueue_Read_Out;

  typedef struct packed {
    logic re;
  } struct_resultQueue_Read_In;

endpackage

package pkg_resultWriter;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_CNT_W      = 16;
  localparam int BYTES_PER_WORD = DEF_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    POP,
    CAPTURE,
    WRITE,
    HEADER,
    DONE
  } state_e;

endpackage

// File: rtl/result_writer_avm_write_port.sv
// Avalon-MM write port: latches address/data on load and holds the write
// request until the slave drops waitrequest, then pulses accept.
module avm_write_port #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  data_i,
  input  logic              waitrequest_i,
  output logic [ADDR_W-1:0] avm_address_o,
  output logic              avm_write_o,
  output logic [WIDTH-1:0]  avm_writedata_o,
  output logic              accept_o
);

  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  data_q, data_d;

  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_i) begin
      write_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
    end else if (write_q && !waitrequest_i) begin
      write_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      write_q <= write_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign accept_o        = write_q & ~waitrequest_i;
  assign avm_write_o     = write_q;
  assign avm_address_o   = addr_q;
  assign avm_writedata_o = data_q;

endmodule

// File: rtl/result_writer.sv
// Drains the result queue into memory over Avalon-MM at consecutive words from base.
// Define RESULT_WRITER_HEADER_EN to write a result-count header word at the base address.
module result_writer
  import pkg_resultWriter::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                start,
  input  logic [ADDR_W-1:0]                   base_addr,
  input  logic [CNT_W-1:0]                    max_results,
  input  logic                                frame_done,
  input  structs::struct_resultQueue_Read_Out rqr_out,
  output structs::struct_resultQueue_Read_In  rqr_in,
  output logic [ADDR_W-1:0]                   avm_address,
  output logic                                avm_write,
  output logic [WIDTH-1:0]                    avm_writedata,
  input  logic                                avm_waitrequest,
  output logic                                busy,
  output logic                                done,
  output logic [CNT_W-1:0]                    result_count,
  output logic                                overflow
);

`ifdef RESULT_WRITER_HEADER_EN
  localparam int HDR_WORDS = 1;
`else
  localparam int HDR_WORDS = 0;
`endif
  localparam int BPW = WIDTH / 8;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  max_q, max_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              fdone_q, fdone_d;

  logic              load;
  logic [ADDR_W-1:0] ldAddr;
  logic [WIDTH-1:0]  ldData;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] dataAddr;

  // Data words sit after the optional header; address arithmetic wraps at ADDR_W.
  assign dataAddr = base_q + (ADDR_W'(count_q) + ADDR_W'(HDR_WORDS)) * ADDR_W'(BPW);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    max_d   = max_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    fdone_d = fdone_q;
    load    = 1'b0;
    ldAddr  = dataAddr;
    ldData  = rqr_out.q;
    pop     = 1'b0;
    if (state_q != IDLE && frame_done) fdone_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          max_d   = max_results;
          count_d = '0;
          ovf_d   = 1'b0;
          fdone_d = 1'b0;
          state_d = POLL;
        end
      end
      POLL: begin
        if (!rqr_out.empty) begin
          state_d = POP;
        end else if (fdone_q) begin
          if (HDR_WORDS != 0) begin
            load    = 1'b1;
            ldAddr  = base_q;
            ldData  = WIDTH'(count_q);
            state_d = HEADER;
          end else begin
            state_d = DONE;
          end
        end
      end
      POP: begin
        pop     = !rqr_out.empty;
        state_d = CAPTURE;
      end
      // The popped word is valid now; it is latched straight into the write port.
      CAPTURE: begin
        if (count_q < max_q) begin
          load    = 1'b1;
          state_d = WRITE;
        end else begin
          ovf_d   = 1'b1;
          state_d = POLL;
        end
      end
      WRITE: begin
        if (accept) begin
          count_d = count_q + CNT_W'(1);
          state_d = POLL;
        end
      end
      HEADER: begin
        if (accept) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      base_q  <= '0;
      max_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      max_q   <= max_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      fdone_q <= fdone_d;
    end
  end

  avm_write_port #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_port (
    .clk            (clk),
    .resetn         (resetn),
    .load_i         (load),
    .addr_i         (ldAddr),
    .data_i         (ldData),
    .waitrequest_i  (avm_waitrequest),
    .avm_address_o  (avm_address),
    .avm_write_o    (avm_write),
    .avm_writedata_o(avm_writedata),
    .accept_o       (accept)
  );

  assign rqr_in       = '{re: pop};
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign result_count = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_result_writer.sv
// Self-checking bench for result_writer: a queue model feeds results, a memory
// monitor records writes, and each frame is checked against the expected layout.
module tb_result_writer;

`ifdef RESULT_WRITER_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn, start, frameDone;
  logic [31:0] baseAddr;
  logic [15:0] maxResults;
  structs::struct_resultQueue_Read_Out rqOut;
  structs::struct_resultQueue_Read_In  rqIn;
  logic [31:0] avmAddress, avmWritedata;
  logic        avmWrite, avmWaitrequest, busy, done, overflow;
  logic [15:0] resultCount;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] fifo[$];
  logic [31:0] stim[$];
  logic        qEmpty = 1'b1;
  logic [31:0] qData = '0;
  int          stallN = 0;
  int          stallCycles = 0;

  logic [31:0] wrAddr[$], wrData[$];
  int          popCount = 0, doneCount = 0, writeCycles = 0;
  logic        prevStall = 1'b0;
  logic [31:0] prevAddr = '0, prevData = '0;

  always #5 clk = ~clk;

  assign rqOut          = '{empty: qEmpty, q: qData};
  assign avmWaitrequest = avmWrite && (stallCycles < stallN);

  result_writer dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .base_addr      (baseAddr),
    .max_results    (maxResults),
    .frame_done     (frameDone),
    .rqr_out        (rqOut),
    .rqr_in         (rqIn),
    .avm_address    (avmAddress),
    .avm_write      (avmWrite),
    .avm_writedata  (avmWritedata),
    .avm_waitrequest(avmWaitrequest),
    .busy           (busy),
    .done           (done),
    .result_count   (resultCount),
    .overflow       (overflow)
  );

  // Queue with one-cycle read latency.
  always @(posedge clk) begin
    if (rqIn.re && fifo.size() > 0) begin
      qData  <= fifo.pop_front();
      qEmpty <= (fifo.size() == 0);
    end
  end

  // Slave stalls each write for stallN cycles.
  always @(posedge clk) begin
    if (!avmWrite) stallCycles <= 0;
    else if (avmWaitrequest) stallCycles <= stallCycles + 1;
    else stallCycles <= 0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: write acceptance, stall stability, pop legality.
  always @(negedge clk) begin
    if (prevStall) begin
      check("stall_hold_write", avmWrite, 1'b1);
      check("stall_hold_addr", avmAddress, prevAddr);
      check("stall_hold_data", avmWritedata, prevData);
    end
    if (rqIn.re) begin
      popCount++;
      check("re_while_empty", qEmpty, 1'b0);
    end
    if (avmWrite && resetn) writeCycles++;
    if (avmWrite && !avmWaitrequest && resetn) begin
      wrAddr.push_back(avmAddress);
      wrData.push_back(avmWritedata);
    end
    if (done) doneCount++;
    prevStall = resetn && avmWrite && avmWaitrequest;
    prevAddr  = avmAddress;
    prevData  = avmWritedata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushResult(input logic [31:0] v);
    fifo.push_back(v);
    qEmpty <= 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    check({tag, "_avm_write"}, avmWrite, 1'b0);
    check({tag, "_avm_address"}, avmAddress, 32'h0);
    check({tag, "_avm_writedata"}, avmWritedata, 32'h0);
    check({tag, "_re"}, rqIn.re, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_result_count"}, resultCount, 16'h0);
    check({tag, "_overflow"}, overflow, 1'b0);
  endtask

  task automatic runFrame(input logic [31:0] base, input int maxR, input int stall, input bit restart);
    int n, half, expCount, waited;
    logic [31:0] expAddr;
    n = stim.size();
    half = n / 2;
    stallN = stall;
    wrAddr.delete();
    wrData.delete();
    popCount = 0;
    doneCount = 0;
    writeCycles = 0;
    for (int i = 0; i < half; i++) pushResult(stim[i]);
    baseAddr = base;
    maxResults = 16'(maxR);
    start = 1'b1;
    tick();
    start = 1'b0;
    baseAddr = $urandom;
    maxResults = 16'($urandom);
    check("busy_after_start", busy, 1'b1);
    if (restart) begin
      tick();
      baseAddr = base ^ 32'h0000_0100;
      maxResults = 16'(maxR + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    for (int i = half; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      pushResult(stim[i]);
    end
    tick();
    frameDone = 1'b1;
    tick();
    frameDone = 1'b0;
    waited = 0;
    while (done !== 1'b1 && waited < 2000) begin
      tick();
      waited++;
    end
    check("done_seen", done, 1'b1);
    tick();
    check("busy_after_done", busy, 1'b0);
    check("done_one_cycle", done, 1'b0);
    expCount = (n < maxR) ? n : maxR;
    check("result_count", resultCount, 64'(expCount));
    check("overflow", overflow, 64'(n > maxR));
    check("pop_count", popCount, 64'(n));
    check("queue_drained", qEmpty, 1'b1);
    check("done_pulses", doneCount, 64'd1);
    check("write_cycles", writeCycles, 64'((expCount + H) * (stall + 1)));
    check("write_total", wrAddr.size(), 64'(expCount + H));
    if (wrAddr.size() == expCount + H) begin
      for (int i = 0; i < expCount; i++) begin
        expAddr = base + 32'((i + H) * 4);
        check("data_addr", wrAddr[i], expAddr);
        check("data_word", wrData[i], stim[i]);
      end
`ifdef RESULT_WRITER_HEADER_EN
      check("header_addr", wrAddr[expCount], base);
      check("header_word", wrData[expCount], 64'(expCount));
`endif
    end
  endtask

  task automatic randomStim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back($urandom);
  endtask

  initial begin
    logic [31:0] r;
    int waited;
    resetn = 1'b0;
    start = 1'b0;
    frameDone = 1'b0;
    baseAddr = '0;
    maxResults = '0;
    tick();
    tick();
    checkIdleOutputs("reset");
    resetn = 1'b1;
    tick();

    // Three known results, no stall, then with a two-cycle stall per write.
    stim = '{32'hA, 32'hB, 32'hC};
    runFrame(32'h0000_1000, 8, 0, 1'b0);
    runFrame(32'h0000_1000, 8, 2, 1'b0);

    // Bounded frame: five results, only two written.
    randomStim(5);
    runFrame(32'h0000_2000, 2, 0, 1'b0);

    // Empty frame, then max_results of zero.
    stim.delete();
    runFrame(32'h0000_3000, 4, 1, 1'b0);
    randomStim(3);
    runFrame(32'h0000_4000, 0, 0, 1'b0);

    // Second start while busy must be ignored.
    randomStim(3);
    runFrame(32'h0000_5000, 8, 1, 1'b1);

    // Reset in the middle of a stalled write abandons the frame.
    stallN = 10;
    pushResult(32'h1111_1111);
    pushResult(32'h2222_2222);
    baseAddr = 32'h0000_6000;
    maxResults = 16'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (avmWrite !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    check("write_before_reset", avmWrite, 1'b1);
    resetn = 1'b0;
    tick();
    checkIdleOutputs("mid_write_reset");
    resetn = 1'b1;
    fifo.delete();
    qEmpty <= 1'b1;
    stallN = 0;
    tick();
    randomStim(2);
    runFrame(32'h0000_7000, 8, 0, 1'b0);

    // Address wraps at the top of the space.
    randomStim(4);
    runFrame(32'hFFFF_FFF8, 8, 0, 1'b0);

    for (int k = 0; k < 5; k++) begin
      r = $urandom;
      r[1:0] = 2'b00;
      randomStim($urandom_range(0, 7));
      runFrame(r, $urandom_range(0, 6), $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
